// File: rtl/controle_jogo_memoria_pkg.sv
// Shared state codes, button encodings and default timing for the memory-game controller.
package controle_jogo_memoria_pkg;

  localparam int N_RODADAS_DEF = 16;
  localparam int T_TIMEOUT_DEF = 5000;
  localparam int T_MOSTRA_DEF  = 1000;

  typedef enum logic [3:0] {
    INICIAL        = 4'd0,
    PREPARA        = 4'd1,
    MOSTRA         = 4'd2,
    ESPERA_JOGADA  = 4'd3,
    REGISTRA       = 4'd4,
    COMPARA        = 4'd5,
    ESPERA_NOVA    = 4'd6,
    REGISTRA_NOVA  = 4'd7,
    ESCREVE_NOVA   = 4'd8,
    PROXIMA_RODADA = 4'd9,
    FIM_GANHOU     = 4'd10,
    FIM_PERDEU     = 4'd11,
    FIM_TIMEOUT    = 4'd12
  } estado_t;

  localparam logic [3:0] BOTAO_0 = 4'b0001;
  localparam logic [3:0] BOTAO_1 = 4'b0010;
  localparam logic [3:0] BOTAO_2 = 4'b0100;
  localparam logic [3:0] BOTAO_3 = 4'b1000;

endpackage

// File: rtl/controle_jogo_memoria_contador.sv
// Loadable down-counter; fim flags the last cycle of an enabled count.
module contador_timeout #(
  parameter int W = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clear,
  input  logic         enable,
  input  logic [W-1:0] valor,
  output logic         fim
);

  logic [W-1:0] conta;

  // clear loads duration-1 so fim rises on the duration-th enabled cycle
  always_ff @(posedge clock) begin
    if (reset)                         conta <= '0;
    else if (clear)                    conta <= valor;
    else if (enable && conta != '0)    conta <= conta - W'(1);
  end

  assign fim = enable && (conta == '0);

endmodule

// File: rtl/controle_jogo_memoria.sv
// Memory-game control unit: shows play 0, runs repeat/insert rounds, detects win/loss/timeout.
module controle_jogo_memoria
  import controle_jogo_memoria_pkg::*;
#(
  parameter int N_RODADAS = N_RODADAS_DEF,
  parameter int ADDR_W    = 4,
  parameter int T_TIMEOUT = T_TIMEOUT_DEF,
  parameter int T_MOSTRA  = T_MOSTRA_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              iniciar,
  input  logic [3:0]        botoes,
  input  logic [3:0]        mem_dado,
  output logic [ADDR_W-1:0] mem_endereco,
  output logic              mem_escreve,
  output logic [3:0]        mem_dado_escrita,
  output logic [3:0]        leds,
  output logic              pronto,
  output logic              ganhou,
  output logic              perdeu,
  output logic              db_timeout,
  output logic [ADDR_W-1:0] db_rodada,
  output logic [3:0]        db_estado
);

  localparam int T_MAX = (T_TIMEOUT > T_MOSTRA) ? T_TIMEOUT : T_MOSTRA;
  localparam int TW    = (T_MAX > 1) ? $clog2(T_MAX) : 1;

  estado_t           estado, prox;
  logic [3:0]        botoes_q, jogada_reg;
  logic [ADDR_W-1:0] rodada, endereco;
  logic              jogada, espera;
  logic              tmr_clear, tmr_en, tmr_fim;
  logic [TW-1:0]     tmr_valor;

  assign jogada = (botoes != 4'd0) && (botoes_q == 4'd0);
  assign espera = (estado == ESPERA_JOGADA) || (estado == ESPERA_NOVA);

  always_ff @(posedge clock) begin
    if (reset) estado <= INICIAL;
    else       estado <= prox;
  end

  always_comb begin
    prox         = estado;
    mem_endereco = endereco;
    mem_escreve  = 1'b0;
    leds         = 4'd0;
    tmr_en       = 1'b0;
    case (estado)
      INICIAL:        if (iniciar) prox = PREPARA;
      PREPARA:        prox = MOSTRA;
      MOSTRA: begin
        mem_endereco = '0;
        leds         = mem_dado;
        tmr_en       = 1'b1;
        if (tmr_fim) prox = ESPERA_JOGADA;
      end
      // a play on the expiry cycle wins over the timeout
      ESPERA_JOGADA: begin
        tmr_en = 1'b1;
        if (jogada)       prox = REGISTRA;
        else if (tmr_fim) prox = FIM_TIMEOUT;
      end
      REGISTRA: begin
        leds = jogada_reg;
        prox = COMPARA;
      end
      COMPARA: begin
        if (jogada_reg != mem_dado)                  prox = FIM_PERDEU;
        else if (endereco < rodada)                  prox = ESPERA_JOGADA;
        else if (rodada == ADDR_W'(N_RODADAS - 1))   prox = FIM_GANHOU;
        else                                         prox = ESPERA_NOVA;
      end
      ESPERA_NOVA: begin
        tmr_en = 1'b1;
        if (jogada)       prox = REGISTRA_NOVA;
        else if (tmr_fim) prox = FIM_TIMEOUT;
      end
      REGISTRA_NOVA: begin
        leds = jogada_reg;
        prox = ESCREVE_NOVA;
      end
      ESCREVE_NOVA: begin
        mem_endereco = rodada + ADDR_W'(1);
        mem_escreve  = !reset;
        prox         = PROXIMA_RODADA;
      end
      PROXIMA_RODADA: prox = ESPERA_JOGADA;
      FIM_GANHOU, FIM_PERDEU, FIM_TIMEOUT:
                      if (iniciar) prox = PREPARA;
      default:        prox = INICIAL;
    endcase
  end

  // one timer serves MOSTRA and both wait states; reloaded on every state change
  assign tmr_clear = (prox != estado);
  assign tmr_valor = (prox == MOSTRA) ? TW'(T_MOSTRA - 1) : TW'(T_TIMEOUT - 1);

  contador_timeout #(.W(TW)) u_timer (
    .clock  (clock),
    .reset  (reset),
    .clear  (tmr_clear),
    .enable (tmr_en),
    .valor  (tmr_valor),
    .fim    (tmr_fim)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      botoes_q   <= 4'd0;
      jogada_reg <= 4'd0;
      rodada     <= '0;
      endereco   <= '0;
    end else begin
      botoes_q <= botoes;
      if (jogada && espera) jogada_reg <= botoes;
      case (estado)
        PREPARA: begin
          rodada   <= '0;
          endereco <= '0;
        end
        COMPARA:        if (prox == ESPERA_JOGADA) endereco <= endereco + ADDR_W'(1);
        PROXIMA_RODADA: begin
          rodada   <= rodada + ADDR_W'(1);
          endereco <= '0;
        end
        default: ;
      endcase
    end
  end

  assign mem_dado_escrita = jogada_reg;
  assign pronto           = (estado == FIM_GANHOU) || (estado == FIM_PERDEU) || (estado == FIM_TIMEOUT);
  assign ganhou           = (estado == FIM_GANHOU);
  assign perdeu           = (estado == FIM_PERDEU) || (estado == FIM_TIMEOUT);
  assign db_timeout       = (estado == FIM_TIMEOUT);
  assign db_rodada        = rodada;
  assign db_estado        = estado;

endmodule

// File: tb/tb_controle_jogo_memoria.sv
// Bench for controle_jogo_memoria: directed vector table, corner sequences, random games vs. a rule model.
module tb_controle_jogo_memoria;

  localparam int NR = 16;
  localparam int AW = 4;
  localparam int TT = 40;
  localparam int TM = 7;

  logic          clock = 1'b0;
  logic          reset, iniciar, clr_ram;
  logic [3:0]    botoes, mem_dado, mem_dado_escrita, leds, db_estado;
  logic [AW-1:0] mem_endereco, db_rodada;
  logic          mem_escreve, pronto, ganhou, perdeu, db_timeout;

  logic [3:0] ram [0:15];
  int n_wr = 0;
  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  controle_jogo_memoria #(.N_RODADAS(NR), .ADDR_W(AW), .T_TIMEOUT(TT), .T_MOSTRA(TM)) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .botoes(botoes), .mem_dado(mem_dado),
    .mem_endereco(mem_endereco), .mem_escreve(mem_escreve), .mem_dado_escrita(mem_dado_escrita),
    .leds(leds), .pronto(pronto), .ganhou(ganhou), .perdeu(perdeu), .db_timeout(db_timeout),
    .db_rodada(db_rodada), .db_estado(db_estado)
  );

  // play RAM: combinational read, write at the edge after the strobe
  assign mem_dado = ram[mem_endereco];
  always @(posedge clock) begin
    if (clr_ram) begin
      for (int i = 0; i < 16; i++) ram[i] <= (i == 0) ? 4'b0001 : 4'b0000;
    end else if (mem_escreve) begin
      ram[mem_endereco] <= mem_dado_escrita;
      n_wr <= n_wr + 1;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // press p for 'hold' edges, then wait until 'dly' edges after the press cycle
  task automatic press(input logic [3:0] p, input int hold, input int dly);
    int n;
    n = (dly > hold + 1) ? dly : hold + 1;
    botoes = p;
    for (int k = 1; k <= n; k++) begin
      step();
      if (k == hold) botoes = 4'd0;
    end
  endtask

  task automatic start_game();
    int cnt, bad;
    iniciar = 1'b1;
    step();
    chk("prepara_estado", db_estado, 1);
    iniciar = 1'b0;
    step();
    chk("mostra_estado", db_estado, 2);
    chk("mostra_rodada", db_rodada, 0);
    cnt = 0;
    bad = 0;
    while (db_estado == 4'd2 && cnt < 200) begin
      if (leds !== 4'b0001) bad++;
      cnt++;
      step();
    end
    chk("mostra_len", cnt, TM);
    chk("mostra_leds", bad, 0);
    chk("espera_after_mostra", db_estado, 3);
  endtask

  // Rule model: the player knows the sequence; each press's verdict follows from the game rules.
  task automatic play_game(input int wrong_pct);
    logic [3:0] seq[$];
    logic [3:0] p;
    int w0;
    seq = {};
    seq.push_back(4'b0001);
    start_game();
    w0 = n_wr;
    for (int r = 0; r < NR; r++) begin
      for (int i = 0; i <= r; i++) begin
        repeat ($urandom_range(0, 2)) step();
        p = seq[i];
        if ($urandom_range(0, 99) < wrong_pct)
          do p = 4'($urandom_range(1, 15)); while (p == seq[i]);
        press(p, $urandom_range(1, 3), 3);
        if (p != seq[i]) begin
          chk("rnd_lose_estado", db_estado, 11);
          chk("rnd_lose_flags", {pronto, ganhou, perdeu, db_timeout}, 4'b1010);
          chk("rnd_lose_writes", n_wr - w0, r);
          return;
        end else if (i < r) begin
          chk("rnd_repeat_estado", db_estado, 3);
        end else if (r == NR - 1) begin
          chk("rnd_win_estado", db_estado, 10);
          chk("rnd_win_flags", {pronto, ganhou, perdeu, db_timeout}, 4'b1100);
          chk("rnd_win_writes", n_wr - w0, NR - 1);
          return;
        end else begin
          chk("rnd_nova_estado", db_estado, 6);
        end
        chk("rnd_rodada", db_rodada, r);
      end
      p = 4'b0001 << $urandom_range(0, 3);
      if ($urandom_range(0, 7) == 0) p = 4'($urandom_range(1, 15));
      press(p, $urandom_range(1, 3), 4);
      seq.push_back(p);
      chk("rnd_next_estado", db_estado, 3);
      chk("rnd_next_rodada", db_rodada, r + 1);
      chk("rnd_ram_written", ram[r+1], p);
      chk("rnd_write_count", n_wr - w0, r + 1);
    end
  endtask

  typedef struct {
    logic [3:0] botoes;
    int         hold;
    int         dly;
    logic [3:0] estado;
    logic [3:0] rodada;
    logic [3:0] addr;
    logic [3:0] flags;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int cnt, w;

    // RAM[0]=0001; player inserts 0010 then 0100, then misses play 2 of round 3
    tbl[0] = '{4'b0001, 1, 3, 4'd6, 4'd0, 4'd0, 4'b0000};
    tbl[1] = '{4'b0010, 1, 4, 4'd3, 4'd1, 4'd0, 4'b0000};
    tbl[2] = '{4'b0001, 10, 3, 4'd3, 4'd1, 4'd1, 4'b0000};
    tbl[3] = '{4'b0010, 2, 3, 4'd6, 4'd1, 4'd1, 4'b0000};
    tbl[4] = '{4'b0100, 1, 4, 4'd3, 4'd2, 4'd0, 4'b0000};
    tbl[5] = '{4'b0001, 1, 3, 4'd3, 4'd2, 4'd1, 4'b0000};
    tbl[6] = '{4'b0010, 3, 3, 4'd3, 4'd2, 4'd2, 4'b0000};
    tbl[7] = '{4'b0001, 1, 3, 4'd11, 4'd2, 4'd2, 4'b1010};

    reset = 1'b1; iniciar = 1'b0; botoes = 4'd0; clr_ram = 1'b1;
    step(); step();
    clr_ram = 1'b0;
    chk("reset_estado", db_estado, 0);
    chk("reset_outputs", {leds, pronto, ganhou, perdeu, db_timeout, mem_escreve,
                          mem_endereco, mem_dado_escrita, db_rodada}, 0);
    reset = 1'b0;
    step();
    chk("idle_estado", db_estado, 0);

    start_game();
    w = n_wr;
    for (int i = 0; i < 8; i++) begin
      press(tbl[i].botoes, tbl[i].hold, tbl[i].dly);
      chk($sformatf("vec%0d_estado", i), db_estado, tbl[i].estado);
      chk($sformatf("vec%0d_rodada", i), db_rodada, tbl[i].rodada);
      chk($sformatf("vec%0d_addr", i), mem_endereco, tbl[i].addr);
      chk($sformatf("vec%0d_flags", i), {pronto, ganhou, perdeu, db_timeout}, tbl[i].flags);
    end
    chk("vec_ram1", ram[1], 4'b0010);
    chk("vec_ram2", ram[2], 4'b0100);
    repeat (5) step();
    chk("perdeu_held", db_estado, 11);
    chk("perdeu_writes", n_wr - w, 2);

    // restart from FIM_PERDEU, then let ESPERA_JOGADA expire
    start_game();
    cnt = 0;
    while (db_estado == 4'd3 && cnt < 200) begin
      cnt++;
      step();
    end
    chk("timeout_len", cnt, TT);
    chk("timeout_estado", db_estado, 12);
    chk("timeout_flags", {pronto, ganhou, perdeu, db_timeout}, 4'b1011);

    // a press on the expiry cycle is still a play
    start_game();
    repeat (TT - 1) step();
    press(4'b0001, 1, 3);
    chk("boundary_estado", db_estado, 6);

    // reset in ESPERA_NOVA
    w = n_wr;
    reset = 1'b1;
    step();
    chk("rst_nova_estado", db_estado, 0);
    chk("rst_nova_outputs", {leds, pronto, ganhou, perdeu, db_timeout, mem_escreve, db_rodada}, 0);
    reset = 1'b0;
    repeat (3) step();
    chk("rst_nova_idle", db_estado, 0);
    chk("rst_nova_writes", n_wr - w, 0);

    // reset during ESCREVE_NOVA suppresses the write
    start_game();
    press(4'b0001, 1, 3);
    botoes = 4'b1000;
    step();
    botoes = 4'd0;
    step();
    chk("escreve_estado", db_estado, 8);
    chk("escreve_strobe", mem_escreve, 1);
    w = n_wr;
    reset = 1'b1;
    #1;
    chk("escreve_gated", mem_escreve, 0);
    step();
    reset = 1'b0;
    chk("escreve_rst_estado", db_estado, 0);
    chk("escreve_rst_writes", n_wr - w, 0);
    step();

    play_game(0);
    for (int g = 0; g < 3; g++) play_game(10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
